// File: rtl/health_bar_engine_if.sv
// Damage request channel (valid/ready) and KO notification between game logic and the health bar engine.
// master = game logic side, slave = engine side.
interface health_bar_engine_if #(
  parameter int NUM_BARS = 2,
  parameter int HW       = 8
);
  localparam int BW = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

  logic          hit_valid;
  logic          hit_ready;
  logic [BW-1:0] hit_bar;
  logic [HW-1:0] hit_amount;
  logic          ko_valid;
  logic [BW-1:0] ko_bar;

  modport master (output hit_valid, hit_bar, hit_amount, input hit_ready, ko_valid, ko_bar);
  modport slave  (input hit_valid, hit_bar, hit_amount, output hit_ready, ko_valid, ko_bar);
endinterface

// File: rtl/health_bar_engine.sv
// Health state, refill/drain animation and 1-cycle pixel classifier; hit_ready only in PLAY, hits stall otherwise.
// Optional HEALTH_BAR_MIRROR_EN: odd-indexed bars fill right-to-left.
module health_bar_engine #(
  parameter int NUM_BARS   = 2,
  parameter int BAR_W      = 144,
  parameter int BAR_H      = 12,
  parameter int BAR_X0     = 16,
  parameter int BAR_Y0     = 16,
  parameter int BAR_PITCH  = 480,
  parameter int DRAIN_STEP = 2,
  parameter int FILL_STEP  = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_tick,
  input  logic                 round_start,
  health_bar_engine_if.slave   hit_if,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  output logic                 pixel_on,
  output logic [1:0]           pixel_color,
  output logic [NUM_BARS-1:0]  bar_empty
);
  localparam int HMAX = BAR_W - 2;
  localparam int HW   = $clog2(HMAX + 1);
  localparam int BW   = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_KO   = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [HW-1:0] target     [NUM_BARS];
  logic [HW-1:0] shown      [NUM_BARS];
  logic [HW-1:0] target_nxt [NUM_BARS];
  logic [HW-1:0] shown_nxt  [NUM_BARS];
  logic          xfer, ko_nxt, all_full;
  logic [2:0]    pix_nxt, cl;

  function automatic logic [HW-1:0] fill_val(input logic [HW-1:0] v);
    int s;
    s = int'(v) + FILL_STEP;
    return (s >= HMAX) ? HW'(HMAX) : HW'(s);
  endfunction

  // Ghost falls by DRAIN_STEP but never below the target it is chasing.
  function automatic logic [HW-1:0] drain_val(input logic [HW-1:0] shw, input logic [HW-1:0] tgt);
    return (int'(shw) - int'(tgt) > DRAIN_STEP) ? HW'(int'(shw) - DRAIN_STEP) : tgt;
  endfunction

  // Returns {inside, colour} for one bar.
  function automatic logic [2:0] classify(input logic [9:0] x, input logic [9:0] y, input int idx,
                                          input logic [HW-1:0] tgt, input logic [HW-1:0] shw);
    int dx, dy, c;
    logic [2:0] r;
    r  = 3'b000;
    dx = int'(x) - (BAR_X0 + idx * BAR_PITCH);
    dy = int'(y) - BAR_Y0;
    if (dx >= 0 && dx < BAR_W && dy >= 0 && dy < BAR_H) begin
      if (dx == 0 || dx == BAR_W-1 || dy == 0 || dy == BAR_H-1) begin
        r = 3'b101;
      end else begin
        c = dx - 1;
`ifdef HEALTH_BAR_MIRROR_EN
        if (idx % 2 == 1) c = HMAX - 1 - c;
`endif
        if (c < int'(tgt))      r = 3'b110;
        else if (c < int'(shw)) r = 3'b111;
        else                    r = 3'b100;
      end
    end
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    xfer      = hit_if.hit_valid && hit_if.hit_ready && !round_start;
    ko_nxt    = 1'b0;
    all_full  = 1'b1;
    for (int i = 0; i < NUM_BARS; i++) begin
      target_nxt[i] = target[i];
      shown_nxt[i]  = shown[i];
    end
    case (state)
      S_FILL: begin
        if (frame_tick) begin
          for (int i = 0; i < NUM_BARS; i++) begin
            target_nxt[i] = fill_val(target[i]);
            shown_nxt[i]  = fill_val(target[i]);
            if (fill_val(target[i]) != HW'(HMAX)) all_full = 1'b0;
          end
          if (all_full) state_nxt = S_PLAY;
        end
      end
      S_PLAY, S_KO: begin
        if (frame_tick) begin
          for (int i = 0; i < NUM_BARS; i++) shown_nxt[i] = drain_val(shown[i], target[i]);
        end
        if (state == S_PLAY && xfer && int'(hit_if.hit_bar) < NUM_BARS) begin
          for (int i = 0; i < NUM_BARS; i++) begin
            if (hit_if.hit_bar == BW'(i)) begin
              target_nxt[i] = (hit_if.hit_amount >= target[i]) ? '0 : target[i] - hit_if.hit_amount;
              if (hit_if.hit_amount >= target[i]) begin
                ko_nxt    = 1'b1;
                state_nxt = S_KO;
              end
            end
          end
        end
      end
      default: ;
    endcase
    // A new round overrides anything else happening this cycle, including a pending hit.
    if (round_start) state_nxt = S_FILL;
  end

  // Iterate high to low so the lowest-index bar wins on overlap.
  always_comb begin
    pix_nxt = 3'b000;
    cl      = 3'b000;
    for (int i = NUM_BARS-1; i >= 0; i--) begin
      cl = classify(DrawX, DrawY, i, target[i], shown[i]);
      if (cl[2]) pix_nxt = cl;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state            <= S_IDLE;
      hit_if.hit_ready <= 1'b0;
      hit_if.ko_valid  <= 1'b0;
      hit_if.ko_bar    <= '0;
      bar_empty        <= '1;
      pixel_on         <= 1'b0;
      pixel_color      <= 2'd0;
      for (int i = 0; i < NUM_BARS; i++) begin
        target[i] <= '0;
        shown[i]  <= '0;
      end
    end else begin
      state            <= state_nxt;
      hit_if.hit_ready <= (state_nxt == S_PLAY);
      hit_if.ko_valid  <= ko_nxt;
      if (ko_nxt) hit_if.ko_bar <= hit_if.hit_bar;
      pixel_on         <= pix_nxt[2];
      pixel_color      <= pix_nxt[1:0];
      for (int i = 0; i < NUM_BARS; i++) begin
        target[i]    <= target_nxt[i];
        shown[i]     <= shown_nxt[i];
        bar_empty[i] <= (target_nxt[i] == '0);
      end
    end
  end
endmodule

// File: tb/tb_health_bar_engine.sv
// Scoreboard bench: driver updates a behavioural model and queues expected pixel/KO responses; a monitor checks them.
module tb_health_bar_engine;
  localparam int NB = 2, HW = 8, BW = 1;
  localparam int BAR_W = 144, BAR_H = 12, X0 = 16, Y0 = 16, PITCH = 480;
  localparam int HMAX = BAR_W - 2, FILL = 4, DRAIN = 2;
  localparam int P_IDLE = 0, P_FILL = 1, P_PLAY = 2, P_KO = 3;

  logic          Clk = 1'b0;
  logic          Reset, frame_tick, round_start;
  logic [9:0]    DrawX, DrawY;
  logic          pixel_on;
  logic [1:0]    pixel_color;
  logic [NB-1:0] bar_empty;

  health_bar_engine_if #(.NUM_BARS(NB), .HW(HW)) hif ();

  health_bar_engine dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .round_start(round_start),
    .hit_if(hif), .DrawX(DrawX), .DrawY(DrawY),
    .pixel_on(pixel_on), .pixel_color(pixel_color), .bar_empty(bar_empty)
  );

  always #5 Clk = ~Clk;

  typedef struct { int due; logic [2:0] exp; int x; int y; } pix_t;
  typedef struct { int due; int bar; } ko_t;
  pix_t pq[$];
  ko_t  kq[$];
  int   cyc = 0;
  int   nchecks = 0, nerr = 0;
  int   m_tgt[NB], m_shw[NB], m_phase;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected {pixel_on, colour}; bars are located by dividing the offset by the pitch.
  function automatic logic [2:0] ref_pixel(input int x, input int y);
    int dx, b, off, col;
    dx = x - X0;
    if (dx < 0 || y < Y0 || y >= Y0 + BAR_H) return 3'b000;
    b   = dx / PITCH;
    off = dx % PITCH;
    if (b >= NB || off >= BAR_W) return 3'b000;
    if (off == 0 || off == BAR_W-1 || y == Y0 || y == Y0 + BAR_H - 1) return 3'b101;
    col = off - 1;
`ifdef HEALTH_BAR_MIRROR_EN
    if (b % 2 == 1) begin
      if (col >= HMAX - m_tgt[b]) return 3'b110;
      if (col >= HMAX - m_shw[b]) return 3'b111;
      return 3'b100;
    end
`endif
    if (col < m_tgt[b]) return 3'b110;
    if (col < m_shw[b]) return 3'b111;
    return 3'b100;
  endfunction

  // One clock of stimulus: check visible state, queue expectations, advance the model.
  task automatic cyc_drive(input logic ft, input logic rs, input logic hv, input int hb, input int ha,
                           input logic pv, input int px, input int py);
    int p;
    logic rdy, xfer, full;
    logic [NB-1:0] be;
    p   = m_phase;
    rdy = (p == P_PLAY);
    for (int i = 0; i < NB; i++) be[i] = (m_tgt[i] == 0);
    check("hit_ready", hif.hit_ready, rdy);
    check("bar_empty", bar_empty, be);
    frame_tick = ft; round_start = rs;
    hif.hit_valid = hv; hif.hit_bar = hb[BW-1:0]; hif.hit_amount = ha[HW-1:0];
    DrawX = px[9:0]; DrawY = py[9:0];
    if (pv) pq.push_back('{due: cyc + 1, exp: ref_pixel(px, py), x: px, y: py});
    xfer = hv && rdy && !rs;
    if (p == P_FILL && ft) begin
      full = 1'b1;
      for (int i = 0; i < NB; i++) begin
        m_tgt[i] = (m_tgt[i] + FILL > HMAX) ? HMAX : m_tgt[i] + FILL;
        m_shw[i] = m_tgt[i];
        if (m_tgt[i] != HMAX) full = 1'b0;
      end
      if (full) m_phase = P_PLAY;
    end
    if ((p == P_PLAY || p == P_KO) && ft)
      for (int i = 0; i < NB; i++) m_shw[i] = (m_shw[i] - DRAIN > m_tgt[i]) ? m_shw[i] - DRAIN : m_tgt[i];
    if (xfer && hb < NB) begin
      m_tgt[hb] = (m_tgt[hb] > ha) ? m_tgt[hb] - ha : 0;
      if (m_tgt[hb] == 0) begin
        kq.push_back('{due: cyc + 1, bar: hb});
        m_phase = P_KO;
      end
    end
    if (rs) m_phase = P_FILL;
    @(posedge Clk); #1;
  endtask

  task automatic idle();             cyc_drive(0, 0, 0, 0, 0, 0, 0, 0);  endtask
  task automatic tick();             cyc_drive(1, 0, 0, 0, 0, 0, 0, 0);  endtask
  task automatic probe(int x, int y); cyc_drive(0, 0, 0, 0, 0, 1, x, y); endtask
  task automatic hit(int b, int a);  cyc_drive(0, 0, 1, b, a, 0, 0, 0);  endtask

  task automatic do_reset(input int n);
    Reset = 1'b1; frame_tick = 0; round_start = 0; hif.hit_valid = 0;
    hif.hit_bar = '0; hif.hit_amount = '0; DrawX = '0; DrawY = '0;
    repeat (n) begin @(posedge Clk); #1; end
    for (int i = 0; i < NB; i++) begin m_tgt[i] = 0; m_shw[i] = 0; end
    m_phase = P_IDLE;
    Reset = 1'b0;
    check("reset hit_ready", hif.hit_ready, 0);
    check("reset pixel_on", pixel_on, 0);
    check("reset pixel_color", pixel_color, 0);
    check("reset ko_valid", hif.ko_valid, 0);
    check("reset bar_empty", bar_empty, {NB{1'b1}});
  endtask

  task automatic refill(input int ticks);
    cyc_drive(0, 1, 0, 0, 0, 0, 0, 0);
    repeat (ticks) begin tick(); idle(); end
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      if (pq.size() > 0 && pq[0].due == cyc) begin
        pix_t e;
        e = pq.pop_front();
        check($sformatf("pixel_on x=%0d y=%0d", e.x, e.y), pixel_on, e.exp[2]);
        check($sformatf("pixel_color x=%0d y=%0d", e.x, e.y), pixel_color, e.exp[1:0]);
      end
      if (kq.size() > 0 && kq[0].due == cyc) begin
        ko_t k;
        k = kq.pop_front();
        check("ko_valid pulse", hif.ko_valid, 1);
        check("ko_bar", hif.ko_bar, k.bar);
      end else begin
        check("ko_valid quiet", hif.ko_valid, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge Clk); #1;
    do_reset(3);
    probe(16, 16); probe(17, 20); probe(15, 20); probe(497, 20);

    refill(36);
    probe(16, 16); probe(17, 20); probe(15, 20); probe(497, 20);
    for (int x = 0; x <= 660; x++) probe(x, 20);
    for (int x = 0; x <= 660; x += 7) begin probe(x, 16); probe(x, 27); probe(x, 28); end
    for (int y = 10; y <= 30; y++) probe(159, y);

    hit(0, 10); idle();
    for (int x = 149; x <= 158; x++) probe(x, 20);
    repeat (5) begin tick(); idle(); end
    for (int x = 145; x <= 160; x++) probe(x, 20);

    hit(1, 0); idle();
    for (int x = 494; x <= 640; x++) probe(x, 20);

    // round_start beats a same-cycle hit
    cyc_drive(0, 1, 1, 1, 50, 0, 0, 0);
    for (int x = 494; x <= 640; x += 3) probe(x, 20);
    repeat (40) begin tick(); idle(); end

    hit(1, 200); idle(); idle(); hit(0, 5); idle();
    for (int x = 494; x <= 640; x += 2) probe(x, 20);
    repeat (20) begin tick(); probe($urandom_range(490, 645), 20); end
    for (int x = 494; x <= 640; x += 2) probe(x, 20);

    refill(40);
    for (int n = 0; n < 4000; n++) begin
      logic ft, rs, hv, pv;
      int ha;
      ft = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 299) == 0);
      hv = ($urandom_range(0, 3) == 0);
      pv = ($urandom_range(0, 1) == 1);
      ha = ($urandom_range(0, 9) == 0) ? $urandom_range(100, 200) : $urandom_range(0, 12);
      cyc_drive(ft, rs, hv, $urandom_range(0, NB-1), ha, pv, $urandom_range(0, 700), $urandom_range(12, 31));
    end

    refill(40);
    hit(0, 30); idle(); tick(); idle();
    do_reset(2);
    for (int x = 0; x <= 660; x += 3) probe(x, 20);
    repeat (3) idle();

    check("pixel queue drained", pq.size(), 0);
    check("ko queue drained", kq.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end
endmodule
